refresh_scheduler: RTL and testbench

Issues periodic DRAM refreshes and drives the query side of the write-usage peak tracker.
- Generates tREFI ticks and keeps a count of owed refreshes.
- For each owed refresh, pulses to_refresh to the tracker and samples its dref decision.
- If dref=1 (dummy), the refresh is skipped. If dref=0 (auto), it requests a REF slot from the command scheduler via req/ack, then blocks the bank group for tRFC.

---
 rtl/refresh_pkg.sv | 23 ++
 rtl/refi_timer.sv | 31 +++
 rtl/refresh_scheduler.sv | 130 +++++++++++++
 tb/tb_refresh_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/refresh_pkg.sv
// Shared types and defaults for the DRAM refresh scheduler.
// Default timing is in controller clock cycles.
package refresh_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    QUERY  = 3'd1,
    DECIDE = 3'd2,
    REQ    = 3'd3,
    RFC    = 3'd4
  } ref_state_e;

  localparam int T_REFI_DEF       = 7800;
  localparam int T_RFC_DEF        = 350;
  localparam int MAX_POSTPONE_DEF = 8;
  localparam int STAT_W_DEF       = 16;

  // Bits needed to hold 0..max_postpone owed refreshes.
  function automatic int pend_w(input int max_postpone);
    return (max_postpone < 1) ? 1 : $clog2(max_postpone + 1);
  endfunction

endpackage

// File: rtl/refi_timer.sv
// Free-running tREFI interval timer: one-cycle tick on the last count, then wraps.
// Dropping en holds the count at 0 and suppresses ticks.
module refi_timer
  import refresh_pkg::*;
#(
  parameter int T_REFI = T_REFI_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  localparam logic [CW-1:0] LAST = CW'(T_REFI - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Periodic refresh scheduler: accumulates owed refreshes, asks the peak tracker
// whether each one may be skipped, and otherwise issues a REF and blocks for tRFC.
module refresh_scheduler
  import refresh_pkg::*;
#(
  parameter int T_REFI       = T_REFI_DEF,
  parameter int T_RFC        = T_RFC_DEF,
  parameter int MAX_POSTPONE = MAX_POSTPONE_DEF,
  parameter int STAT_W       = STAT_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            init_done,
  output logic                            to_refresh,
  input  logic                            dref,
  output logic                            ref_req,
  input  logic                            ref_ack,
  output logic                            ref_busy,
  output logic                            ref_urgent,
  output logic [pend_w(MAX_POSTPONE)-1:0] pending_cnt,
  output logic                            overflow,
  output logic [STAT_W-1:0]               issue_cnt,
  output logic [STAT_W-1:0]               skip_cnt
);

  localparam int PW = pend_w(MAX_POSTPONE);
  localparam int RW = (T_RFC > 1) ? $clog2(T_RFC) : 1;
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_POSTPONE);
  localparam logic [RW-1:0] RFC_LAST = RW'(T_RFC - 1);

  ref_state_e    state;
  ref_state_e    state_nxt;
  logic [RW-1:0] rfc_cnt;
  logic          tick;
  logic          skip_done;
  logic          issue_done;
  logic          complete;

  refi_timer #(
    .T_REFI (T_REFI)
  ) u_refi_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (init_done),
    .tick  (tick)
  );

  // Handshake: a REF transfers on any cycle where ref_req and ref_ack are both
  // high; ref_req stays asserted until then and ref_ack outside REQ has no effect.
  assign skip_done  = (state == DECIDE) && dref;
  assign issue_done = (state == REQ) && ref_ack;
  assign complete   = skip_done || issue_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    to_refresh = 1'b0;
    ref_req    = 1'b0;
    ref_busy   = 1'b0;
    case (state)
      IDLE: begin
        if (pending_cnt != '0) state_nxt = QUERY;
      end
      QUERY: begin
        to_refresh = 1'b1;
        state_nxt  = DECIDE;
      end
      DECIDE: begin
        state_nxt = dref ? IDLE : REQ;
      end
      REQ: begin
        ref_req = 1'b1;
        if (ref_ack) state_nxt = RFC;
      end
      RFC: begin
        ref_busy = 1'b1;
        if (rfc_cnt == RFC_LAST) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfc_cnt <= '0;
    end else if (state == RFC) begin
      rfc_cnt <= rfc_cnt + 1'b1;
    end else begin
      rfc_cnt <= '0;
    end
  end

  // A tick and a completion in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else if (tick && !complete) begin
      if (pending_cnt == PEND_MAX) begin
        overflow <= 1'b1;
      end else begin
        pending_cnt <= pending_cnt + 1'b1;
      end
    end else if (!tick && complete) begin
      pending_cnt <= pending_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      skip_cnt  <= '0;
    end else begin
      if (issue_done) issue_cnt <= issue_cnt + 1'b1;
      if (skip_done)  skip_cnt  <= skip_cnt + 1'b1;
    end
  end

  assign ref_urgent = (pending_cnt == PEND_MAX);

endmodule

// File: tb/tb_refresh_scheduler.sv
// Bench for refresh_scheduler with T_REFI=20, T_RFC=5, MAX_POSTPONE=4.
// Each to_refresh pulse pushes the driven decision; each skip/issue pops it.
module tb_refresh_scheduler;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        to_refresh;
  logic        dref = 1'b1;
  logic        ref_req;
  logic        ref_ack = 1'b0;
  logic        ref_busy;
  logic        ref_urgent;
  logic [2:0]  pending_cnt;
  logic        overflow;
  logic [15:0] issue_cnt;
  logic [15:0] skip_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  // monitor bookkeeping
  logic        mon_en = 1'b0;
  logic        prev_to = 1'b0;
  logic        req_seen = 1'b0;
  int          pulses = 0;
  int          busy_len = 0;
  logic [15:0] prev_skip = '0;
  logic [15:0] prev_issue = '0;

  refresh_scheduler #(
    .T_REFI       (20),
    .T_RFC        (5),
    .MAX_POSTPONE (4),
    .STAT_W       (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_done   (init_done),
    .to_refresh  (to_refresh),
    .dref        (dref),
    .ref_req     (ref_req),
    .ref_ack     (ref_ack),
    .ref_busy    (ref_busy),
    .ref_urgent  (ref_urgent),
    .pending_cnt (pending_cnt),
    .overflow    (overflow),
    .issue_cnt   (issue_cnt),
    .skip_cnt    (skip_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    init_done = 1'b0;
    ref_ack   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_to_refresh", to_refresh, 0);
    check("rst_ref_req", ref_req, 0);
    check("rst_ref_busy", ref_busy, 0);
    check("rst_urgent", ref_urgent, 0);
    check("rst_pending", pending_cnt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_issue", issue_cnt, 0);
    check("rst_skip", skip_cnt, 0);
    exp_q.delete();
    prev_to    = 1'b0;
    req_seen   = 1'b0;
    pulses     = 0;
    busy_len   = 0;
    prev_skip  = '0;
    prev_issue = '0;
    rst_n      = 1'b1;
    mon_en     = 1'b1;
    cyc        = 0;
  endtask

  // scoreboard / protocol monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (to_refresh) begin
        check("to_refresh_width", prev_to, 0);
        exp_q.push_back(dref);
        pulses++;
      end
      prev_to = to_refresh;
      if (ref_req) req_seen = 1'b1;
      if (skip_cnt != prev_skip) begin
        check("skip_step", skip_cnt, prev_skip + 16'd1);
        if (exp_q.size() == 0) check("sb_depth", exp_q.size(), 1);
        else check("svc_kind_skip", 1, exp_q.pop_front());
        prev_skip = skip_cnt;
      end
      if (issue_cnt != prev_issue) begin
        check("issue_step", issue_cnt, prev_issue + 16'd1);
        if (exp_q.size() == 0) check("sb_depth", exp_q.size(), 1);
        else check("svc_kind_issue", 0, exp_q.pop_front());
        prev_issue = issue_cnt;
      end
      if (ref_busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        check("rfc_len", busy_len, 5);
        busy_len = 0;
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // basic skip
    dref = 1'b1;
    do_reset();
    init_done = 1'b1;
    goto(19); check("s1_pend_c19", pending_cnt, 0);
    goto(20); check("s1_pend_c20", pending_cnt, 1);
              check("s1_toref_c20", to_refresh, 0);
    goto(21); check("s1_toref_c21", to_refresh, 1);
    goto(22); check("s1_toref_c22", to_refresh, 0);
              check("s1_skip_c22", skip_cnt, 0);
    goto(23); check("s1_skip_c23", skip_cnt, 1);
              check("s1_pend_c23", pending_cnt, 0);
    goto(30); check("s1_no_req", req_seen, 0);

    // auto refresh, ack tied high
    dref = 1'b0;
    do_reset();
    ref_ack = 1'b1;
    init_done = 1'b1;
    goto(22); check("s2_req_c22", ref_req, 0);
    goto(23); check("s2_req_c23", ref_req, 1);
              check("s2_pend_c23", pending_cnt, 1);
    goto(24); check("s2_req_c24", ref_req, 0);
              check("s2_issue_c24", issue_cnt, 1);
              check("s2_pend_c24", pending_cnt, 0);
              check("s2_busy_c24", ref_busy, 1);
    goto(28); check("s2_busy_c28", ref_busy, 1);
    goto(29); check("s2_busy_c29", ref_busy, 0);

    // withheld ack: saturation and overflow, then drain
    dref = 1'b0;
    do_reset();
    init_done = 1'b1;
    goto(79); check("s3_pend_c79", pending_cnt, 3);
              check("s3_urg_c79", ref_urgent, 0);
    goto(80); check("s3_pend_c80", pending_cnt, 4);
              check("s3_urg_c80", ref_urgent, 1);
    goto(99); check("s3_req_c99", ref_req, 1);
              check("s3_ovf_c99", overflow, 0);
    goto(100); check("s3_ovf_c100", overflow, 1);
               check("s3_pend_c100", pending_cnt, 4);
    ref_ack = 1'b1;
    init_done = 1'b0;
    goto(101); check("s3_pend_c101", pending_cnt, 3);
               check("s3_issue_c101", issue_cnt, 1);
    goto(109); check("s3_req_c109", ref_req, 1);
    goto(110); check("s3_pend_c110", pending_cnt, 2);
    goto(119); check("s3_pend_c119", pending_cnt, 1);
    goto(128); check("s3_pend_c128", pending_cnt, 0);
               check("s3_issue_c128", issue_cnt, 4);
               check("s3_ovf_c128", overflow, 1);
    goto(140); check("s3_drain", exp_q.size(), 0);

    // tick and handshake on the same edge
    dref = 1'b0;
    do_reset();
    init_done = 1'b1;
    goto(39); check("s4_pend_c39", pending_cnt, 1);
              check("s4_req_c39", ref_req, 1);
    ref_ack = 1'b1;
    goto(40); check("s4_pend_c40", pending_cnt, 1);
              check("s4_issue_c40", issue_cnt, 1);
    goto(49); check("s4_pend_c49", pending_cnt, 0);
              check("s4_issue_c49", issue_cnt, 2);

    // init_done held low
    dref = 1'b1;
    do_reset();
    goto(50); check("s5_pend_low", pending_cnt, 0);
              check("s5_pulses_low", pulses, 0);
    cyc = 0;
    init_done = 1'b1;
    goto(19); check("s5_pend_c19", pending_cnt, 0);
    goto(20); check("s5_pend_c20", pending_cnt, 1);
    goto(21); check("s5_toref_c21", to_refresh, 1);

    // asynchronous reset on the third tRFC cycle
    dref = 1'b0;
    do_reset();
    ref_ack = 1'b1;
    init_done = 1'b1;
    goto(24); check("s6_busy_c24", ref_busy, 1);
              check("s6_issue_c24", issue_cnt, 1);
    goto(26); check("s6_busy_c26", ref_busy, 1);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("s6_busy_async", ref_busy, 0);
    check("s6_req_async", ref_req, 0);
    check("s6_issue_async", issue_cnt, 0);
    check("s6_pend_async", pending_cnt, 0);
    dref = 1'b1;
    do_reset();
    init_done = 1'b1;
    goto(19); check("s6_pend_c19", pending_cnt, 0);
    goto(20); check("s6_pulses_c20", pulses, 0);
              check("s6_pend_c20", pending_cnt, 1);
    goto(21); check("s6_toref_c21", to_refresh, 1);
    goto(23); check("s6_skip_c23", skip_cnt, 1);
    init_done = 1'b0;
    goto(50); check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
